ucode_seq: RTL and testbench

Parametrised microcode sequencer for the 65C02-family cores. It generalises the fixed 512x36 controller: the control width, microcode depth, opcode width, finisher field and return-stack depth are all configurable. It adds conditional micro-branches, micro-subroutine call/return, and a ready-based stall. It sits between the data bus (opcode fetch) and the datapath decoders (ALU, AB, DP, DO), which slice the registered control word themselves.

---
 rtl/ucode_pkg.sv | 26 ++
 rtl/ucode_seq_if.sv | 25 ++
 rtl/ucode_rstack.sv | 47 ++++
 rtl/ucode_seq.sv | 165 ++++++++++++++++
 tb/tb_ucode_seq.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/ucode_pkg.sv
// Shared definitions for the 65C02 microcode sequencer: SEQ opcodes,
// control-word field positions and sizing helpers.
package ucode_pkg;

   typedef enum logic [2:0] {
      SEQ_DECODE    = 3'b000,
      SEQ_NEXT      = 3'b001,
      SEQ_FINISH    = 3'b010,
      SEQ_NEXT_SAVE = 3'b011,
      SEQ_CALL      = 3'b100,
      SEQ_RET       = 3'b101,
      SEQ_BRANCH    = 3'b110,
      SEQ_RSVD      = 3'b111
   } seq_e;

   localparam int SEQ_LSB = 32;
   localparam int SEQ_W   = 3;
   localparam int WE_BIT  = 35;
   localparam int FIN_LSB = 10;

   // Stack pointer must count 0..SD inclusive.
   function automatic int sp_width(input int sd);
      return $clog2(sd + 1);
   endfunction

endpackage

// File: rtl/ucode_seq_if.sv
// Opcode-fetch / control-word bundle between the bus side and the sequencer.
interface ucode_seq_if #(
   parameter int CW  = 36,
   parameter int AW  = 9,
   parameter int OPW = 8
);
   logic           rdy;
   logic [OPW-1:0] DB;
   logic           cond;
   logic [CW-1:0]  control;
   logic           sync;
   logic           WE;
   logic [AW-1:0]  upc;
   logic           err;

   modport master (
      output rdy, DB, cond,
      input  control, sync, WE, upc, err
   );

   modport slave (
      input  rdy, DB, cond,
      output control, sync, WE, upc, err
   );
endinterface

// File: rtl/ucode_rstack.sv
// Micro-subroutine return stack. Push on a full stack and pop on an empty
// stack are ignored here; the sequencer flags them as errors.
module ucode_rstack
   import ucode_pkg::*;
#(
   parameter int AW = 9,
   parameter int SD = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [AW-1:0] din,
   output logic [AW-1:0] dout,
   output logic          full,
   output logic          empty
);

   localparam int SPW   = sp_width(SD);
   localparam int DEPTH = 1 << SPW;
   localparam logic [SPW-1:0] SP_MAX = SPW'(SD);
   localparam logic [SPW-1:0] SP_ONE = SPW'(1);

   logic [SPW-1:0] sp;
   logic [AW-1:0]  mem [DEPTH];

   assign full  = (sp == SP_MAX);
   assign empty = (sp == '0);
   assign dout  = mem[sp - SP_ONE];

   // Stack pointer; reset alone discards the contents.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         sp <= '0;
      else if (push && !full)
         sp <= sp + SP_ONE;
      else if (pop && !empty)
         sp <= sp - SP_ONE;
   end

   // Entry storage; slots at or above sp are never read.
   always_ff @(posedge clk) begin
      if (push && !full)
         mem[sp] <= din;
   end

endmodule

// File: rtl/ucode_seq.sv
// Parametrised microcode sequencer: chooses the next microcode address from
// the SEQ field of the registered control word, reads the ROM synchronously
// and stalls everything while rdy is low.
// Optional macro UCODE_SEQ_PARITY_EN: ROM carries an even-parity MSB; a bad
// word sets err and restarts at the reset finisher.
//
//   SEQ | meaning
//   000 | DECODE     next = {0,DB} (opcode fetch, sync=1)
//   001 | NEXT       next = {1,TGT}
//   010 | FINISH     next = FIN_BASE + finish
//   011 | NEXT_SAVE  next = {1,TGT}, finish <= FIN
//   100 | CALL       push upc+1, next = {1,TGT}
//   101 | RET        next = pop (empty: {0,DB} and err)
//   110 | BRANCH     next = cond ? {1,TGT} : upc+1
//   111 | reserved   decode and err
module ucode_seq
   import ucode_pkg::*;
#(
   parameter int              CW        = 36,
   parameter int              AW        = 9,
   parameter int              OPW       = 8,
   parameter int              FW        = 5,
   parameter int              SD        = 4,
   parameter logic [AW-1:0]   FIN_BASE  = 9'h140,
   parameter logic [FW-1:0]   RESET_FIN = '0,
   parameter string           ROM_FILE  = "microcode.hex"
) (
   input  logic       clk,
   input  logic       reset,
   ucode_seq_if.slave bus
);

`ifdef UCODE_SEQ_PARITY_EN
   localparam int RW = CW + 1;
`else
   localparam int RW = CW;
`endif
   localparam int DEPTH = 1 << AW;
   localparam logic [CW-1:0] RESET_CTRL = CW'(SEQ_FINISH) << SEQ_LSB;
`ifdef UCODE_SEQ_PARITY_EN
   localparam logic [RW-1:0] RESET_WORD  = {^RESET_CTRL, RESET_CTRL};
   localparam logic [AW-1:0] RECOVER_ADR = FIN_BASE + AW'(RESET_FIN);
`else
   localparam logic [RW-1:0] RESET_WORD  = RESET_CTRL;
`endif

   logic [RW-1:0]   rom [DEPTH];
   logic [RW-1:0]   word_q;
   logic [CW-1:0]   ctrl;
   logic [AW-1:0]   upc_q;
   logic            we_q;
   logic [FW-1:0]   finish_q;
   logic            err_q;

   logic [AW-1:0]   nxt;
   logic            push;
   logic            pop;
   logic            save_fin;
   logic            err_set;
   seq_e            seq;
   logic [AW-2:0]   tgt;
   logic [FW-1:0]   fin_f;
   logic [AW-1:0]   upc_inc;
   logic [AW-1:0]   stk_top;
   logic            stk_full;
   logic            stk_empty;

   assign ctrl    = word_q[CW-1:0];
   assign seq     = seq_e'(ctrl[SEQ_LSB +: SEQ_W]);
   assign tgt     = ctrl[AW-2:0];
   assign fin_f   = ctrl[FIN_LSB +: FW];
   assign upc_inc = upc_q + AW'(1);

`ifdef UCODE_SEQ_PARITY_EN
   logic par_err;
   assign par_err = ^word_q;
`endif

   ucode_rstack #(.AW(AW), .SD(SD)) u_rstack (
      .clk   (clk),
      .reset (reset),
      .push  (push && bus.rdy),
      .pop   (pop && bus.rdy),
      .din   (upc_inc),
      .dout  (stk_top),
      .full  (stk_full),
      .empty (stk_empty)
   );

   // Sequencer state: control word, address, WE pipeline, finisher and err.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word_q   <= RESET_WORD;
         upc_q    <= '0;
         we_q     <= 1'b0;
         finish_q <= RESET_FIN;
         err_q    <= 1'b0;
      end else if (bus.rdy) begin
         word_q <= rom[nxt];
         upc_q  <= nxt;
         we_q   <= ctrl[WE_BIT];
         if (save_fin)
            finish_q <= fin_f;
         if (err_set)
            err_q <= 1'b1;
      end
   end

   // Next-address selection and side effects from the current SEQ op.
   always_comb begin
      nxt      = {1'b0, bus.DB};
      push     = 1'b0;
      pop      = 1'b0;
      save_fin = 1'b0;
      err_set  = 1'b0;
      case (seq)
         SEQ_DECODE:    nxt = {1'b0, bus.DB};
         SEQ_NEXT:      nxt = {1'b1, tgt};
         SEQ_FINISH:    nxt = FIN_BASE + AW'(finish_q);
         SEQ_NEXT_SAVE: begin
            nxt      = {1'b1, tgt};
            save_fin = 1'b1;
         end
         SEQ_CALL: begin
            nxt     = {1'b1, tgt};
            push    = 1'b1;
            err_set = stk_full;
         end
         SEQ_RET: begin
            if (stk_empty) begin
               nxt     = {1'b0, bus.DB};
               err_set = 1'b1;
            end else begin
               nxt = stk_top;
               pop = 1'b1;
            end
         end
         SEQ_BRANCH:    nxt = bus.cond ? {1'b1, tgt} : upc_inc;
         default: begin
            nxt     = {1'b0, bus.DB};
            err_set = 1'b1;
         end
      endcase
`ifdef UCODE_SEQ_PARITY_EN
      // A corrupted word cannot be trusted to touch the stack or finisher.
      if (par_err) begin
         nxt      = RECOVER_ADR;
         push     = 1'b0;
         pop      = 1'b0;
         save_fin = 1'b0;
         err_set  = 1'b1;
      end
`endif
   end

   // Outputs follow the held word; sync is independent of rdy.
   always_comb begin
      bus.control = ctrl;
      bus.upc     = upc_q;
      bus.WE      = we_q;
      bus.err     = err_q;
      bus.sync    = (seq == SEQ_DECODE);
   end

endmodule

// File: tb/tb_ucode_seq.sv
// Bench for ucode_seq: directed microprogram with literal expectations,
// then random ROM images and random rdy/DB/cond, all compared each cycle
// against a queue-based behavioural model.
module tb_ucode_seq;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   ucode_seq_if #(.CW(36), .AW(9), .OPW(8)) bus();

   ucode_seq #(
      .CW(36), .AW(9), .OPW(8), .FW(5), .SD(4),
      .FIN_BASE(9'h140), .RESET_FIN(5'd0), .ROM_FILE("")
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   localparam int SD = 4;

   int errs   = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   logic [35:0] rom_m [512];
   logic [35:0] m_ctrl;
   int          m_upc;
   int          m_fin;
   bit          m_we;
   bit          m_err;
   int          m_stk[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic put(input int a, input logic [35:0] w);
      rom_m[a] = w;
`ifdef UCODE_SEQ_PARITY_EN
      dut.rom[a] = {^w, w};
`else
      dut.rom[a] = w;
`endif
   endtask

   task automatic rand_rom();
      logic [35:0] w;
      for (int a = 0; a < 512; a++) begin
         w[31:0]  = $urandom;
         w[35]    = 1'($urandom_range(0, 1));
         w[34:32] = ($urandom_range(0, 31) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
         put(a, w);
      end
   endtask

   task automatic model_reset();
      m_ctrl = 36'h2_0000_0000;
      m_upc  = 0;
      m_we   = 1'b0;
      m_fin  = 0;
      m_err  = 1'b0;
      m_stk.delete();
   endtask

   task automatic model_step(input bit r, input logic [7:0] d, input bit c);
      int n;
      int tgt;
      int s;
      if (!r) return;
      s   = int'(m_ctrl[34:32]);
      tgt = int'(m_ctrl[7:0]);
      n   = int'(d);
      case (s)
         0: n = int'(d);
         1: n = 256 + tgt;
         2: n = (320 + m_fin) % 512;
         3: begin n = 256 + tgt; m_fin = int'(m_ctrl[14:10]); end
         4: begin
            if (m_stk.size() < SD) m_stk.push_back((m_upc + 1) % 512);
            else m_err = 1'b1;
            n = 256 + tgt;
         end
         5: begin
            if (m_stk.size() == 0) begin n = int'(d); m_err = 1'b1; end
            else n = m_stk.pop_back();
         end
         6: n = c ? 256 + tgt : (m_upc + 1) % 512;
         default: begin n = int'(d); m_err = 1'b1; end
      endcase
      m_we   = m_ctrl[35];
      m_upc  = n;
      m_ctrl = rom_m[n];
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("control", bus.control, m_ctrl);
         chk("upc", bus.upc, m_upc);
         chk("sync", bus.sync, m_ctrl[34:32] == 3'd0);
         chk("WE", bus.WE, m_we);
         chk("err", bus.err, m_err);
      end
   end

   task automatic cyc(input bit r, input logic [7:0] d, input bit c);
      bus.rdy  = r;
      bus.DB   = d;
      bus.cond = c;
      @(posedge clk);
      if (!reset) model_step(r, d, c);
      #1;
   endtask

   task automatic do_reset(input bit reload);
      reset = 1'b1;
      model_reset();
      if (reload) rand_rom();
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   initial begin
      bus.rdy  = 1'b0;
      bus.DB   = '0;
      bus.cond = 1'b0;
      rand_rom();
      put(9'h140, 36'h0_00AB_C05A);
      put(9'h0A9, 36'hB_0000_1420);
      put(9'h120, 36'h2_0000_7C00);
      put(9'h145, 36'h9_0000_0030);
      put(9'h130, 36'h4_0000_0050);
      put(9'h150, 36'h5_0000_0000);
      put(9'h131, 36'h1_0000_0010);
      put(9'h110, 36'h6_0000_0040);
      put(9'h011, 36'h1_0000_0010);
      put(9'h111, 36'h5_0000_0000);
      put(9'h022, 36'h0_0000_0000);
      put(9'h033, 36'h1_0000_0060);
      for (int i = 0; i < 5; i++) put(9'h160 + i, 36'h4_0000_0061 + 36'(i));
      put(9'h165, 36'h0_0000_0000);

      #1 reset = 1'b1;
      model_reset();
      chk_en = 1'b1;
      #1;
      chk("rst_control", bus.control, 36'h2_0000_0000);
      chk("rst_upc", bus.upc, 9'h000);
      chk("rst_WE", bus.WE, 1'b0);
      chk("rst_err", bus.err, 1'b0);
      chk("rst_sync", bus.sync, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;

      cyc(1, 8'h00, 0);
      chk("first_control", bus.control, 36'h0_00AB_C05A);
      chk("first_upc", bus.upc, 9'h140);
      chk("first_WE", bus.WE, 1'b0);
      chk("first_err", bus.err, 1'b0);
      chk("first_sync", bus.sync, 1'b1);
      cyc(1, 8'hA9, 0);
      chk("decode_upc", bus.upc, 9'h0A9);
      chk("decode_sync", bus.sync, 1'b0);
      cyc(1, 8'h00, 0);
      chk("save_upc", bus.upc, 9'h120);
      chk("save_WE", bus.WE, 1'b1);
      cyc(1, 8'h00, 0);
      chk("finish_upc", bus.upc, 9'h145);
      cyc(1, 8'h00, 0);
      chk("next_upc", bus.upc, 9'h130);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 8'h5A, 1);
         chk("stall_upc", bus.upc, 9'h130);
         chk("stall_control", bus.control, 36'h4_0000_0050);
         chk("stall_WE", bus.WE, 1'b1);
      end
      cyc(1, 8'h00, 0);
      chk("call_upc", bus.upc, 9'h150);
      chk("call_WE", bus.WE, 1'b0);
      cyc(1, 8'h00, 0);
      chk("ret_upc", bus.upc, 9'h131);
      cyc(1, 8'h00, 0);
      cyc(1, 8'h00, 1);
      chk("branch_taken_upc", bus.upc, 9'h140);
      cyc(1, 8'h11, 0);
      cyc(1, 8'h00, 0);
      cyc(1, 8'h00, 0);
      chk("branch_fall_upc", bus.upc, 9'h111);
      chk("pre_empty_err", bus.err, 1'b0);
      cyc(1, 8'h22, 0);
      chk("empty_ret_upc", bus.upc, 9'h022);
      chk("empty_ret_err", bus.err, 1'b1);

      do_reset(0);
      chk("reset_clears_err", bus.err, 1'b0);
      cyc(1, 8'h00, 0);
      cyc(1, 8'h33, 0);
      cyc(1, 8'h00, 0);
      chk("nest_start_upc", bus.upc, 9'h160);
      for (int i = 0; i < 4; i++) cyc(1, 8'h00, 0);
      chk("nest4_upc", bus.upc, 9'h164);
      chk("nest4_err", bus.err, 1'b0);
      cyc(1, 8'h00, 0);
      chk("overflow_upc", bus.upc, 9'h165);
      chk("overflow_err", bus.err, 1'b1);

      for (int i = 0; i < 4000; i++) begin
         if (i % 1000 == 0)
            do_reset(1);
         else if (i % 250 == 0)
            do_reset(0);
         else
            cyc($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom));
      end

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
